sync_fifo_ctrl_mem: RTL and testbench
=====================================

// Module: sync_fifo_ctrl_mem
// PURPOSE
//  Single-clock FIFO: dual-port storage array plus pointer/count control. Adds occupancy
//  count, programmable almost-full/almost-empty flags, sticky overflow/underflow error
//  flags and a selectable read mode (registered or first-word-fall-through, FWFT).
//  Sits between same-clock producer/consumer stages wherever a CDC FIFO is not needed.
// PARAMETERS
//  DATASIZE  8            data word width (bits)
//  ADDRSIZE  4            address bits; DEPTH = 1<<ADDRSIZE words
//  FWFT      0            0 = registered read (1-cycle latency); 1 = head word visible while !rempty
//  AFULL_TH  DEPTH-2      wafull asserted when count >= AFULL_TH (legal range 1..DEPTH)
//  AEMPTY_TH 2            raempty asserted when count <= AEMPTY_TH (legal range 0..DEPTH-1)
// PORTS
//  clk      in   1           single clock, all logic on posedge
//  rst      in   1           synchronous, active-high reset
//  winc     in   1           write request
//  wdata    in   DATASIZE    write data
//  wfull    out  1           FIFO holds DEPTH words
//  wafull   out  1           almost full
//  rinc     in   1           read request (FWFT=1: pop of the presented head word)
//  rdata    out  DATASIZE    read data
//  rvalid   out  1           FWFT=0: rdata valid this cycle; FWFT=1: equals !rempty
//  rempty   out  1           FIFO holds 0 words
//  raempty  out  1           almost empty
//  count    out  ADDRSIZE+1  current occupancy, 0..DEPTH
//  ovf      out  1           sticky: write attempted while wfull
//  udf      out  1           sticky: read attempted while rempty
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wptr=rptr=0, count=0, rempty=1, raempty=1, wfull=0,
//    wafull=(AFULL_TH==0 ? 1 : 0), rvalid=0, ovf=0, udf=0, rdata=0 (FWFT=0). Array contents
//    are not cleared. Reset mid-operation discards all stored words; the next cycle starts empty.
//  - Write accepted iff winc && !wfull: mem[wptr]<=wdata, wptr<=wptr+1 (mod DEPTH).
//  - Read accepted iff rinc && !rempty: rptr<=rptr+1 (mod DEPTH).
//  - Flags are evaluated on registered state at the clock edge. A write while full is rejected
//    even if a read is accepted in the same cycle; a read while empty is rejected even if a
//    write is accepted in the same cycle.
//  - count: +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds
//    DEPTH and never goes below 0.
//  - wfull, wafull, rempty and raempty are registered and derived from next-count, so they are
//    valid in the cycle after the update. Comparisons are unsigned on ADDRSIZE+1 bits.
//  - ovf is set by winc && wfull; udf is set by rinc && rempty. Both hold until rst.
//    Rejected accesses change no pointer, count or data.
//  - FWFT=0: on an accepted read, rdata<=mem[rptr] and rvalid<=1 on the next cycle.
//    Otherwise rvalid<=0 and rdata holds its last value.
//  - FWFT=1: rdata=mem[rptr] combinationally; rvalid=!rempty. A word written at edge N is
//    visible from cycle N+1 (rempty deasserts then).
//  - Pointers wrap naturally at DEPTH. Full and empty are distinguished by count, not by
//    pointer equality.
//  - Same-address read/write (count==0 with write, or wrap) gives no read-during-write bypass,
//    because an empty FIFO is never read.
// STRUCTURE
//  - Shared package sync_fifo_pkg: default DATASIZE/ADDRSIZE, DEPTH function
//    (1<<ADDRSIZE), read-mode constants MODE_REG=0 / MODE_FWFT=1.
//  - One sub-module, sync_fifo_ram: DEPTH x DATASIZE array with synchronous write (wclken)
//    and combinational read port. The FWFT=0 output register lives in the control logic.
//  - Top level holds the pointers, count, flag registers, error flags and the read-mode
//    generate block.
// TESTING (DATASIZE=8, ADDRSIZE=4, AFULL_TH=14, AEMPTY_TH=2)
//  1 Reset then write 0x00..0x0F on 16 cycles -> count=16, wfull=1, wafull=1 from count 14,
//    ovf=0; a 17th write -> ovf=1, count stays 16.
//  2 From full, read 16 (FWFT=0) -> rdata 0x00..0x0F each one cycle after rinc, rvalid pulses
//    in step; rempty=1 at the end; one extra rinc -> udf=1, rvalid=0.
//  3 count=8, winc=rinc=1 for 20 cycles -> count stays 8, pointers wrap past 15, data order
//    preserved.
//  4 Full FIFO, winc=rinc=1 -> read accepted, write rejected, ovf=1, count=15.
//    Empty FIFO, winc=rinc=1 -> write accepted, udf=1, count=1.
//  5 FWFT=1: write 0xA5 at edge N -> rdata=0xA5, rvalid=1 at N+1 with no rinc; rinc pops it
//    -> rempty=1.
//  6 Load 10 words, assert rst for 1 cycle mid-stream -> count=0, rempty=1, ovf=udf=0;
//    subsequent writes/reads return the new data only.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO.
//  - DEF_DATASIZE / DEF_ADDRSIZE : default word width and address width
//  - depth_f()                   : number of words for a given address width
//  - MODE_REG / MODE_FWFT        : read-mode selectors for the FWFT parameter
package sync_fifo_pkg;

   localparam int unsigned DEF_DATASIZE = 8;
   localparam int unsigned DEF_ADDRSIZE = 4;

   localparam int unsigned MODE_REG  = 0;
   localparam int unsigned MODE_FWFT = 1;

   function automatic int unsigned depth_f(int unsigned addrsize);
      return 32'd1 << addrsize;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for the FIFO: DEPTH x DATASIZE words.
//  clk    : clock, write on posedge
//  wclken : write enable
//  waddr  : write address
//  wdata  : write data
//  raddr  : read address
//  rdata  : combinational read data (mem[raddr])
// Contents are never reset.
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATASIZE = DEF_DATASIZE,
   parameter int unsigned ADDRSIZE = DEF_ADDRSIZE
) (
   input  logic                clk,
   input  logic                wclken,
   input  logic [ADDRSIZE-1:0] waddr,
   input  logic [DATASIZE-1:0] wdata,
   input  logic [ADDRSIZE-1:0] raddr,
   output logic [DATASIZE-1:0] rdata
);

   localparam int unsigned DEPTH = depth_f(ADDRSIZE);

   logic [DATASIZE-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wclken) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ctrl_mem.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags, sticky
// overflow/underflow flags and a selectable read mode.
//  clk, rst : clock and synchronous active-high reset
//  winc     : write request, wdata : write data
//  wfull    : DEPTH words stored, wafull : count >= AFULL_TH
//  rinc     : read request (FWFT mode: pop the presented head word)
//  rdata    : read data, rvalid : registered-mode data valid / FWFT-mode !rempty
//  rempty   : no words stored, raempty : count <= AEMPTY_TH
//  count    : occupancy 0..DEPTH
//  ovf, udf : sticky write-while-full / read-while-empty
module sync_fifo_ctrl_mem
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATASIZE  = DEF_DATASIZE,
   parameter int unsigned ADDRSIZE  = DEF_ADDRSIZE,
   parameter int unsigned FWFT      = MODE_REG,
   parameter int unsigned AFULL_TH  = depth_f(ADDRSIZE) - 2,
   parameter int unsigned AEMPTY_TH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                winc,
   input  logic [DATASIZE-1:0] wdata,
   output logic                wfull,
   output logic                wafull,
   input  logic                rinc,
   output logic [DATASIZE-1:0] rdata,
   output logic                rvalid,
   output logic                rempty,
   output logic                raempty,
   output logic [ADDRSIZE:0]   count,
   output logic                ovf,
   output logic                udf
);

   localparam int unsigned CW = ADDRSIZE + 1;
   localparam logic [ADDRSIZE:0] DEPTH_C  = CW'(depth_f(ADDRSIZE));
   localparam logic [ADDRSIZE:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [ADDRSIZE:0] AEMPTY_C = CW'(AEMPTY_TH);

   logic [ADDRSIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ADDRSIZE:0]   count_q, count_d;
   logic                wfull_q, wfull_d, wafull_q, wafull_d;
   logic                rempty_q, rempty_d, raempty_q, raempty_d;
   logic                ovf_q, ovf_d, udf_q, udf_d;
   logic                wr_en, rd_en;
   logic [DATASIZE-1:0] ram_rdata;

   always_comb begin
      // Acceptance uses registered flags only, so a same-cycle pop never frees a slot
      // for a write into a full FIFO (and vice versa for empty).
      wr_en = winc && !wfull_q;
      rd_en = rinc && !rempty_q;

      wptr_d = wr_en ? wptr_q + ADDRSIZE'(1) : wptr_q;
      rptr_d = rd_en ? rptr_q + ADDRSIZE'(1) : rptr_q;

      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      wfull_d   = (count_d == DEPTH_C);
      wafull_d  = (count_d >= AFULL_C);
      rempty_d  = (count_d == '0);
      raempty_d = (count_d <= AEMPTY_C);

      ovf_d = ovf_q | (winc & wfull_q);
      udf_d = udf_q | (rinc & rempty_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         wfull_q   <= 1'b0;
         wafull_q  <= (AFULL_TH == 0);
         rempty_q  <= 1'b1;
         raempty_q <= 1'b1;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         wfull_q   <= wfull_d;
         wafull_q  <= wafull_d;
         rempty_q  <= rempty_d;
         raempty_q <= raempty_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

   sync_fifo_ram #(
      .DATASIZE (DATASIZE),
      .ADDRSIZE (ADDRSIZE)
   ) u_ram (
      .clk    (clk),
      .wclken (wr_en),
      .waddr  (wptr_q),
      .wdata  (wdata),
      .raddr  (rptr_q),
      .rdata  (ram_rdata)
   );

   if (FWFT == MODE_FWFT) begin : g_fwft
      // Head word is presented directly from the array while the FIFO is non-empty.
      assign rdata  = ram_rdata;
      assign rvalid = !rempty_q;
   end else begin : g_reg
      logic [DATASIZE-1:0] rdata_q, rdata_d;
      logic                rvalid_q, rvalid_d;

      always_comb begin
         rdata_d  = rd_en ? ram_rdata : rdata_q;
         rvalid_d = rd_en;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
         end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
   end

   assign wfull   = wfull_q;
   assign wafull  = wafull_q;
   assign rempty  = rempty_q;
   assign raempty = raempty_q;
   assign count   = count_q;
   assign ovf     = ovf_q;
   assign udf     = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl_mem.sv
// Bench for sync_fifo_ctrl_mem: one registered-read instance and one FWFT instance.
module tb_sync_fifo_ctrl_mem;

   logic       clk = 1'b0;
   logic       rst;
   logic       winc, rinc;
   logic [7:0] wdata;
   logic       wfull, wafull, rempty, raempty, rvalid, ovf, udf;
   logic [7:0] rdata;
   logic [4:0] count;

   logic       f_winc, f_rinc;
   logic [7:0] f_wdata;
   logic       f_wfull, f_wafull, f_rempty, f_raempty, f_rvalid, f_ovf, f_udf;
   logic [7:0] f_rdata;
   logic [4:0] f_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] sb [$];
   logic [7:0] fq [$];

   always #5 clk = ~clk;

   sync_fifo_ctrl_mem #(
      .DATASIZE (8), .ADDRSIZE (4), .FWFT (0), .AFULL_TH (14), .AEMPTY_TH (2)
   ) u_reg (
      .clk (clk), .rst (rst), .winc (winc), .wdata (wdata), .wfull (wfull),
      .wafull (wafull), .rinc (rinc), .rdata (rdata), .rvalid (rvalid),
      .rempty (rempty), .raempty (raempty), .count (count), .ovf (ovf), .udf (udf)
   );

   sync_fifo_ctrl_mem #(
      .DATASIZE (8), .ADDRSIZE (4), .FWFT (1), .AFULL_TH (14), .AEMPTY_TH (2)
   ) u_fwft (
      .clk (clk), .rst (rst), .winc (f_winc), .wdata (f_wdata), .wfull (f_wfull),
      .wafull (f_wafull), .rinc (f_rinc), .rdata (f_rdata), .rvalid (f_rvalid),
      .rempty (f_rempty), .raempty (f_raempty), .count (f_count), .ovf (f_ovf),
      .udf (f_udf)
   );

   // Expected {wfull, wafull, rempty, raempty} for a given occupancy.
   function automatic logic [3:0] exp_flags(int c);
      return {c == 16, c >= 14, c == 0, c <= 2};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      fq.delete();
   endtask

   task automatic test_reset();
      winc = 0; rinc = 0; wdata = 0; f_winc = 0; f_rinc = 0; f_wdata = 0;
      do_reset();
      n_cmp++;
      if ({count, wfull, wafull, rempty, raempty, rvalid, ovf, udf, rdata} !==
          {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL reset_state: got cnt=%0d wf=%b waf=%b re=%b rae=%b rv=%b ovf=%b udf=%b rd=%h",
                  count, wfull, wafull, rempty, raempty, rvalid, ovf, udf, rdata);
      end
      n_cmp++;
      if ({f_count, f_rempty, f_rvalid} !== {5'd0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL reset_fwft: got cnt=%0d re=%b rv=%b, want 0 1 0",
                  f_count, f_rempty, f_rvalid);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         winc = 1; wdata = 8'(i); sb.push_back(8'(i));
         step();
         n_cmp++;
         if ({count, wfull, wafull, rempty, raempty, ovf} !==
             {5'(i + 1), exp_flags(i + 1), 1'b0}) begin
            n_err++;
            $display("FAIL fill_%0d: got cnt=%0d flags=%b ovf=%b, want cnt=%0d flags=%b ovf=0",
                     i, count, {wfull, wafull, rempty, raempty}, ovf, i + 1, exp_flags(i + 1));
         end
      end
      wdata = 8'hFF;
      step();
      winc = 0;
      n_cmp++;
      if ({count, ovf, wfull} !== {5'd16, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL fill_overflow: got cnt=%0d ovf=%b wf=%b, want 16 1 1", count, ovf, wfull);
      end
   endtask

   task automatic test_drain();
      logic [7:0] e;
      for (int i = 0; i < 16; i++) begin
         rinc = 1; e = sb.pop_front();
         step();
         n_cmp++;
         if ({rdata, rvalid, count} !== {e, 1'b1, 5'(15 - i)}) begin
            n_err++;
            $display("FAIL drain_%0d: got rd=%h rv=%b cnt=%0d, want %h 1 %0d",
                     i, rdata, rvalid, count, e, 15 - i);
         end
      end
      step();
      rinc = 0;
      n_cmp++;
      if ({udf, rvalid, rempty, rdata, count} !== {1'b1, 1'b0, 1'b1, 8'h0F, 5'd0}) begin
         n_err++;
         $display("FAIL drain_underflow: got udf=%b rv=%b re=%b rd=%h cnt=%0d, want 1 0 1 0f 0",
                  udf, rvalid, rempty, rdata, count);
      end
   endtask

   task automatic test_simul_rw();
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         winc = 1; wdata = 8'h30 + 8'(i); sb.push_back(wdata);
         step();
      end
      for (int i = 0; i < 20; i++) begin
         winc = 1; rinc = 1; wdata = 8'h40 + 8'(i); sb.push_back(wdata);
         e = sb.pop_front();
         step();
         n_cmp++;
         if ({rdata, rvalid, count} !== {e, 1'b1, 5'd8}) begin
            n_err++;
            $display("FAIL simul_%0d: got rd=%h rv=%b cnt=%0d, want %h 1 8",
                     i, rdata, rvalid, count, e);
         end
      end
      winc = 0;
      for (int i = 0; i < 8; i++) begin
         rinc = 1; e = sb.pop_front();
         step();
         n_cmp++;
         if (rdata !== e) begin
            n_err++;
            $display("FAIL simul_tail_%0d: got rd=%h, want %h", i, rdata, e);
         end
      end
      rinc = 0;
   endtask

   task automatic test_full_empty_both();
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         winc = 1; wdata = 8'h50 + 8'(i); sb.push_back(wdata);
         step();
      end
      winc = 1; rinc = 1; wdata = 8'hEE; e = sb.pop_front();
      step();
      n_cmp++;
      if ({count, ovf, wfull, rdata, rvalid} !== {5'd15, 1'b1, 1'b0, e, 1'b1}) begin
         n_err++;
         $display("FAIL full_both: got cnt=%0d ovf=%b wf=%b rd=%h rv=%b, want 15 1 0 %h 1",
                  count, ovf, wfull, rdata, rvalid, e);
      end
      winc = 0;
      for (int i = 0; i < 15; i++) begin
         rinc = 1; e = sb.pop_front();
         step();
         n_cmp++;
         if (rdata !== e) begin
            n_err++;
            $display("FAIL full_drain_%0d: got rd=%h, want %h", i, rdata, e);
         end
      end
      winc = 1; rinc = 1; wdata = 8'h77; sb.push_back(wdata);
      step();
      winc = 0; rinc = 0;
      n_cmp++;
      if ({count, udf, rvalid, rempty} !== {5'd1, 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL empty_both: got cnt=%0d udf=%b rv=%b re=%b, want 1 1 0 0",
                  count, udf, rvalid, rempty);
      end
      rinc = 1; e = sb.pop_front();
      step();
      rinc = 0;
      n_cmp++;
      if ({rdata, rvalid, rempty} !== {e, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL empty_both_read: got rd=%h rv=%b re=%b, want %h 1 1",
                  rdata, rvalid, rempty, e);
      end
   endtask

   task automatic test_fwft();
      logic [7:0] e;
      f_winc = 1; f_wdata = 8'hA5; fq.push_back(8'hA5);
      step();
      f_winc = 0;
      n_cmp++;
      if ({f_rdata, f_rvalid, f_rempty} !== {fq[0], 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL fwft_visible: got rd=%h rv=%b re=%b, want %h 1 0",
                  f_rdata, f_rvalid, f_rempty, fq[0]);
      end
      step();
      n_cmp++;
      if ({f_rdata, f_rvalid, f_count} !== {fq[0], 1'b1, 5'd1}) begin
         n_err++;
         $display("FAIL fwft_hold: got rd=%h rv=%b cnt=%0d, want %h 1 1",
                  f_rdata, f_rvalid, f_count, fq[0]);
      end
      f_rinc = 1; void'(fq.pop_front());
      step();
      f_rinc = 0;
      n_cmp++;
      if ({f_rempty, f_rvalid, f_count} !== {1'b1, 1'b0, 5'd0}) begin
         n_err++;
         $display("FAIL fwft_pop: got re=%b rv=%b cnt=%0d, want 1 0 0",
                  f_rempty, f_rvalid, f_count);
      end
      for (int i = 0; i < 3; i++) begin
         f_winc = 1; f_wdata = 8'h11 * 8'(i + 1); fq.push_back(f_wdata);
         step();
      end
      f_winc = 0;
      for (int i = 0; i < 3; i++) begin
         e = fq.pop_front();
         n_cmp++;
         if ({f_rdata, f_rvalid} !== {e, 1'b1}) begin
            n_err++;
            $display("FAIL fwft_order_%0d: got rd=%h rv=%b, want %h 1", i, f_rdata, f_rvalid, e);
         end
         f_rinc = 1;
         step();
         f_rinc = 0;
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] e;
      // Sticky ovf/udf are still set from the previous scenario.
      for (int i = 0; i < 10; i++) begin
         winc = 1; wdata = 8'h60 + 8'(i);
         step();
      end
      winc = 0;
      n_cmp++;
      if (count !== 5'd10) begin
         n_err++;
         $display("FAIL midrst_load: got cnt=%0d, want 10", count);
      end
      do_reset();
      n_cmp++;
      if ({count, rempty, ovf, udf, rvalid} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL midrst_state: got cnt=%0d re=%b ovf=%b udf=%b rv=%b, want 0 1 0 0 0",
                  count, rempty, ovf, udf, rvalid);
      end
      for (int i = 0; i < 2; i++) begin
         winc = 1; wdata = 8'h90 + 8'(i); sb.push_back(wdata);
         step();
      end
      winc = 0;
      for (int i = 0; i < 2; i++) begin
         rinc = 1; e = sb.pop_front();
         step();
         n_cmp++;
         if ({rdata, rvalid} !== {e, 1'b1}) begin
            n_err++;
            $display("FAIL midrst_read_%0d: got rd=%h rv=%b, want %h 1", i, rdata, rvalid, e);
         end
      end
      rinc = 0;
      step();
      n_cmp++;
      if ({rempty, count, rvalid} !== {1'b1, 5'd0, 1'b0}) begin
         n_err++;
         $display("FAIL midrst_end: got re=%b cnt=%0d rv=%b, want 1 0 0", rempty, count, rvalid);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_simul_rw();
      test_full_empty_both();
      test_fwft();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
